// File: rtl/pulse_event_arbiter.sv
// pulse_event_arbiter
// Latches single-cycle event pulses from several sources as pending requests
// and offers them one at a time, round-robin, to a single consumer over a
// valid/ready handshake. A pulse that hits an already-pending source (and is
// not being accepted in that same cycle) is dropped and counted in a
// saturating counter. Every output comes straight from a register.
module pulse_event_arbiter #(
    parameter  int N_REQ = 4,
    parameter  int CNT_W = 8,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_pulse,
    output logic             ev_valid,
    output logic [ID_W-1:0]  ev_id,
    input  logic             ev_ready,
    input  logic             drop_clr,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    localparam int POP_W = $clog2(N_REQ + 1);
    localparam int SUM_W = CNT_W + POP_W;
    localparam logic [SUM_W-1:0] CNT_MAX = (SUM_W'(1) << CNT_W) - SUM_W'(1);

    state_t             state_reg;
    logic [N_REQ-1:0]   pending_reg;
    logic               ev_valid_reg;
    logic [ID_W-1:0]    ev_id_reg;
    logic [ID_W-1:0]    last_grant_reg;
    logic [CNT_W-1:0]   drop_cnt_reg;
    logic               busy_reg;

    logic               accept;
    logic [N_REQ-1:0]   accept_vec;
    logic [N_REQ-1:0]   drop_vec;
    logic [N_REQ-1:0]   pending_next;
    logic               ev_valid_next;
    logic [ID_W-1:0]    cand_idx [N_REQ];
    logic [ID_W-1:0]    winner_id;
    logic               winner_found;
    logic [POP_W-1:0]   drop_pop;
    logic [SUM_W-1:0]   drop_sum;
    logic [CNT_W-1:0]   drop_cnt_next;

    assign accept = ev_valid_reg && ev_ready;

    // Per-source bookkeeping: accept decode, drop detection, next pending
    // value, and the round-robin search order starting after last_grant.
    // A pulse coinciding with its own accept re-arms the bit instead of
    // being dropped.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign accept_vec[gi]   = accept && (ev_id_reg == ID_W'(gi));
        assign drop_vec[gi]     = req_pulse[gi] && pending_reg[gi] && !accept_vec[gi];
        assign pending_next[gi] = (pending_reg[gi] && !accept_vec[gi]) || req_pulse[gi];
        assign cand_idx[gi]     = ID_W'((int'(last_grant_reg) + gi + 1) % N_REQ);
    end

    // Round-robin pick: first registered pending bit in search order wins.
    always_comb begin
        winner_id    = cand_idx[0];
        winner_found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!winner_found && pending_reg[cand_idx[k]]) begin
                winner_id    = cand_idx[k];
                winner_found = 1'b1;
            end
        end
    end

    // Next value of ev_valid, needed ahead of the edge to register busy.
    always_comb begin
        ev_valid_next = ev_valid_reg;
        if (state_reg == IDLE) begin
            ev_valid_next = |pending_reg;
        end else begin
            ev_valid_next = !ev_ready;
        end
    end

    // Saturating drop counter update; a clear overrides drops in the same cycle.
    always_comb begin
        drop_pop = '0;
        for (int k = 0; k < N_REQ; k++) begin
            drop_pop = drop_pop + POP_W'(drop_vec[k]);
        end
        drop_sum = SUM_W'(drop_cnt_reg) + SUM_W'(drop_pop);
        if (drop_clr) begin
            drop_cnt_next = '0;
        end else if (drop_sum > CNT_MAX) begin
            drop_cnt_next = '1;
        end else begin
            drop_cnt_next = drop_sum[CNT_W-1:0];
        end
    end

    // Offer state machine plus pending, counter and busy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            pending_reg    <= '0;
            ev_valid_reg   <= 1'b0;
            ev_id_reg      <= '0;
            last_grant_reg <= ID_W'(N_REQ - 1);
            drop_cnt_reg   <= '0;
            busy_reg       <= 1'b0;
        end else begin
            pending_reg  <= pending_next;
            drop_cnt_reg <= drop_cnt_next;
            busy_reg     <= (|pending_next) || ev_valid_next;
            case (state_reg)
                IDLE: begin
                    if (|pending_reg) begin
                        ev_id_reg    <= winner_id;
                        ev_valid_reg <= 1'b1;
                        state_reg    <= OFFER;
                    end
                end
                OFFER: begin
                    if (ev_ready) begin
                        last_grant_reg <= ev_id_reg;
                        ev_valid_reg   <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: begin
                    ev_valid_reg <= 1'b0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

    assign ev_valid = ev_valid_reg;
    assign ev_id    = ev_id_reg;
    assign drop_cnt = drop_cnt_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Testbench for pulse_event_arbiter: directed scenarios with constant
// expectations plus a randomized run checked against a behavioural model.
module tb_pulse_event_arbiter;

    localparam int N     = 4;
    localparam int CW    = 2;
    localparam int MAXC  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_pulse = '0;
    logic          ev_valid;
    logic [1:0]    ev_id;
    logic          ev_ready = 1'b0;
    logic          drop_clr = 1'b0;
    logic [CW-1:0] drop_cnt;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [N-1:0] m_pend;
    bit           m_valid;
    int           m_id;
    int           m_last;
    int           m_cnt;
    bit           m_busy;

    pulse_event_arbiter #(.N_REQ(N), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_pulse (req_pulse),
        .ev_valid  (ev_valid),
        .ev_id     (ev_id),
        .ev_ready  (ev_ready),
        .drop_clr  (drop_clr),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock edge using the rules of the block.
    task automatic model_step(input logic [N-1:0] p, input logic rd, input logic cl, input logic rs);
        int acc;
        int nd;
        bit found;
        logic [N-1:0] np;
        if (rs) begin
            m_pend = '0; m_valid = 0; m_id = 0; m_last = N - 1; m_cnt = 0; m_busy = 0;
            return;
        end
        acc = (m_valid && rd) ? m_id : -1;
        nd  = 0;
        np  = m_pend;
        for (int i = 0; i < N; i++) begin
            if (p[i]) begin
                if (m_pend[i] && acc != i) nd++;
                np[i] = 1'b1;
            end else if (acc == i) begin
                np[i] = 1'b0;
            end
        end
        m_cnt = cl ? 0 : ((m_cnt + nd > MAXC) ? MAXC : m_cnt + nd);
        if (!m_valid) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && m_pend[(m_last + k) % N]) begin
                    m_id    = (m_last + k) % N;
                    m_valid = 1;
                    found   = 1;
                end
            end
        end else if (rd) begin
            m_last  = m_id;
            m_valid = 0;
        end
        m_pend = np;
        m_busy = (np != 0) || m_valid;
    endtask

    // Drive one cycle of inputs, clock it, update the model, settle.
    task automatic cycle(input logic [N-1:0] p, input logic rd, input logic cl, input logic rs);
        req_pulse = p; ev_ready = rd; drop_clr = cl; rst = rs;
        @(posedge clk);
        model_step(p, rd, cl, rs);
        #1;
    endtask

    task automatic test_reset;
        cycle(4'b0000, 1'b0, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 1'b0, 1'b1);
        checks++;
        if (ev_valid !== 1'b0 || ev_id !== 2'd0 || drop_cnt !== 2'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset: valid=%b id=%0d drop=%0d busy=%b, required 0 0 0 0", ev_valid, ev_id, drop_cnt, busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_single;
        cycle(4'b0100, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ev_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_t1: valid=%b busy=%b, required 0 1", ev_valid, busy);
        end
        cycle(4'b0000, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ev_valid !== 1'b1 || ev_id !== 2'd2) begin
            failures++;
            $display("FAIL single_t2: valid=%b id=%0d, required 1 2", ev_valid, ev_id);
        end
        cycle(4'b0000, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ev_valid !== 1'b0 || busy !== 1'b0 || drop_cnt !== 2'd0) begin
            failures++;
            $display("FAIL single_after: valid=%b busy=%b drop=%0d, required 0 0 0", ev_valid, busy, drop_cnt);
        end
        $display("test_single done");
    endtask

    task automatic test_fairness;
        cycle(4'b0000, 1'b0, 1'b0, 1'b1);
        cycle(4'b1111, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            cycle(4'b0000, 1'b1, 1'b0, 1'b0);
            checks++;
            if (ev_valid !== 1'(k % 2) || (ev_valid === 1'b1 && ev_id !== 2'((k - 1) / 2))) begin
                failures++;
                $display("FAIL fair_k%0d: valid=%b id=%0d, required valid=%0d id=%0d", k, ev_valid, ev_id, k % 2, (k - 1) / 2);
            end
        end
        cycle(4'b1001, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            cycle(4'b0000, 1'b1, 1'b0, 1'b0);
            checks++;
            if (ev_valid !== 1'(k % 2) || (ev_valid === 1'b1 && ev_id !== ((k == 1) ? 2'd0 : 2'd3))) begin
                failures++;
                $display("FAIL fair_re_k%0d: valid=%b id=%0d, required valid=%0d id=%0d", k, ev_valid, ev_id, k % 2, (k == 1) ? 0 : 3);
            end
        end
        $display("test_fairness done");
    endtask

    task automatic test_drop_stall;
        logic [N-1:0] pat [6];
        pat = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000};
        cycle(4'b0010, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            cycle(pat[k], 1'b0, 1'b0, 1'b0);
            if (k >= 1) begin
                checks++;
                if (ev_valid !== 1'b1 || ev_id !== 2'd1) begin
                    failures++;
                    $display("FAIL stall_hold_%0d: valid=%b id=%0d, required 1 1", k, ev_valid, ev_id);
                end
            end
        end
        checks++;
        if (drop_cnt !== 2'd2) begin
            failures++;
            $display("FAIL stall_drops: drop_cnt=%0d, required 2", drop_cnt);
        end
        cycle(4'b0000, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            cycle(4'b0000, 1'b1, 1'b0, 1'b0);
            checks++;
            if (ev_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL stall_single_delivery_%0d: valid=%b busy=%b, required 0 0", k, ev_valid, busy);
            end
        end
        $display("test_drop_stall done");
    endtask

    task automatic test_pulse_during_accept;
        cycle(4'b0001, 1'b0, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ev_valid !== 1'b1 || ev_id !== 2'd0) begin
            failures++;
            $display("FAIL pda_offer: valid=%b id=%0d, required 1 0", ev_valid, ev_id);
        end
        cycle(4'b0001, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ev_valid !== 1'b0 || drop_cnt !== 2'd2 || busy !== 1'b1) begin
            failures++;
            $display("FAIL pda_accept: valid=%b drop=%0d busy=%b, required 0 2 1", ev_valid, drop_cnt, busy);
        end
        cycle(4'b0000, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ev_valid !== 1'b1 || ev_id !== 2'd0) begin
            failures++;
            $display("FAIL pda_reoffer: valid=%b id=%0d, required 1 0", ev_valid, ev_id);
        end
        cycle(4'b0000, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ev_valid !== 1'b0 || busy !== 1'b0 || drop_cnt !== 2'd2) begin
            failures++;
            $display("FAIL pda_drain: valid=%b busy=%b drop=%0d, required 0 0 2", ev_valid, busy, drop_cnt);
        end
        $display("test_pulse_during_accept done");
    endtask

    task automatic test_saturation_clear;
        cycle(4'b0000, 1'b0, 1'b1, 1'b0);
        checks++;
        if (drop_cnt !== 2'd0) begin
            failures++;
            $display("FAIL sat_clear0: drop_cnt=%0d, required 0", drop_cnt);
        end
        cycle(4'b0001, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            cycle(4'b0001, 1'b0, 1'b0, 1'b0);
            checks++;
            if (drop_cnt !== 2'((k > MAXC) ? MAXC : k)) begin
                failures++;
                $display("FAIL sat_drop%0d: drop_cnt=%0d, required %0d", k, drop_cnt, (k > MAXC) ? MAXC : k);
            end
        end
        cycle(4'b0001, 1'b0, 1'b1, 1'b0);
        checks++;
        if (drop_cnt !== 2'd0) begin
            failures++;
            $display("FAIL sat_clear_wins: drop_cnt=%0d, required 0", drop_cnt);
        end
        cycle(4'b0000, 1'b1, 1'b0, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ev_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL sat_drain: valid=%b busy=%b, required 0 0", ev_valid, busy);
        end
        $display("test_saturation_clear done");
    endtask

    task automatic test_reset_mid_offer;
        cycle(4'b0110, 1'b0, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ev_valid !== 1'b1 || ev_id !== 2'd1) begin
            failures++;
            $display("FAIL rmo_offer: valid=%b id=%0d, required 1 1", ev_valid, ev_id);
        end
        cycle(4'b0000, 1'b0, 1'b0, 1'b1);
        checks++;
        if (ev_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rmo_reset: valid=%b busy=%b, required 0 0", ev_valid, busy);
        end
        for (int k = 0; k < 5; k++) begin
            cycle(4'b0000, 1'b1, 1'b0, 1'b0);
            checks++;
            if (ev_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL rmo_quiet_%0d: valid=%b busy=%b, required 0 0", k, ev_valid, busy);
            end
        end
        $display("test_reset_mid_offer done");
    endtask

    task automatic test_random;
        logic [N-1:0] p;
        logic rd, cl, rs;
        for (int t = 0; t < 600; t++) begin
            p  = ($urandom_range(0, 9) < 4) ? N'($urandom_range(1, 15)) : '0;
            rd = ($urandom_range(0, 3) != 0);
            cl = ($urandom_range(0, 24) == 0);
            rs = ($urandom_range(0, 199) == 0);
            cycle(p, rd, cl, rs);
            checks++;
            if (ev_valid !== 1'(m_valid) || (m_valid && ev_id !== 2'(m_id)) ||
                drop_cnt !== CW'(m_cnt) || busy !== 1'(m_busy)) begin
                failures++;
                $display("FAIL random_t%0d: valid=%b id=%0d drop=%0d busy=%b, required %0d %0d %0d %0d",
                         t, ev_valid, ev_id, drop_cnt, busy, m_valid, m_id, m_cnt, m_busy);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        m_pend = '0; m_valid = 0; m_id = 0; m_last = N - 1; m_cnt = 0; m_busy = 0;
        test_reset();
        test_single();
        test_fairness();
        test_drop_stall();
        test_pulse_during_accept();
        test_saturation_clear();
        test_reset_mid_offer();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
